calc_job_scheduler: RTL and testbench
=====================================

Name: calc_job_scheduler

Overview:
- Shares the small-calculator datapath and its control unit between two requesters.
- Arbitrates round-robin between the two requesters and latches one job (op, A, B).
- Sequences the calculator with a one-cycle go pulse, waits for done, and returns the result with the requester id.
- Sits between the host-side requesters and the calculator top; one job in flight at a time.

Parameters:
- WIDTH, 4, operand/result width of the calculator datapath.
- TIMEOUT, 16, max cycles in WAIT before an error response; must be at least 8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this cycle
- req0_op  in  2  opcode: 3=ADD, 2=SUB, 1=AND, 0=XOR
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0
- calc_go  out  1  go pulse to the calculator control unit
- calc_op  out  2  opcode to the calculator; held for the whole job
- calc_a  out  WIDTH  operand written in WRITE1; held for the whole job
- calc_b  out  WIDTH  operand written in WRITE2; held for the whole job
- calc_done  in  1  calculator OUTPUT-state flag
- calc_result  in  WIDTH  calculator output; valid while calc_done=1
- resp_valid  out  1  response available
- resp_ready  in  1  response consumer ready
- resp_id  out  1  requester that issued the job
- resp_data  out  WIDTH  result; 0 on error
- resp_err  out  1  timeout error flag
- busy  out  1  state is not IDLE
- jobs_done  out  8  count of successful responses; wraps 255 to 0

Behaviour:
- Reset: state=IDLE, rr_ptr=1 (so req0 wins first), all outputs 0.
  - Reset is asynchronous and may occur in any state, mid-job included.
  - Any job in flight is dropped; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP (2-bit encoding, values 0 to 3).
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the requester not equal to rr_ptr.
  - reqN_ready = (state==IDLE) && grantN. Ready is combinational and never asserted to both requesters.
  - On valid&&ready: latch op/a/b/id, set rr_ptr=id, go to ISSUE.
  - Ready does not depend on resp_ready.
- ISSUE: calc_go=1 for exactly one cycle, then WAIT. Clear the timeout counter.
- WAIT:
  - calc_go=0 and the counter increments each cycle.
  - If calc_done=1: latch calc_result, set err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set data=0, err=1, go to RESP.
  - If calc_done arrives on the timeout cycle, done wins.
- calc_done outside WAIT is ignored.
- calc_op/a/b are registered from the latch and stay stable from ISSUE until the exit from RESP.
- RESP:
  - resp_valid=1; resp_id/data/err stay stable until resp_ready=1.
  - On the handshake: go to IDLE; if err=0, jobs_done+1.
  - No new request is accepted in the handshake cycle.
  - resp_valid drops the cycle after the handshake.
- Nominal latency: request handshake at cycle N, ISSUE at N+1, calculator done at N+6, resp_valid at N+7. Minimum 8 cycles between accepted jobs.
- After a timeout, the calculator is not reset by this block. System rst resets both blocks.

Decomposition:
- Shared package calc_pkg:
  - Opcode constants ADD=3, SUB=2, AND=1, XOR=0.
  - Scheduler state encodings.
  - Calculator control-unit state encodings for bench monitors.
- One sub-module, calc_rr_arb2: 2-way round-robin grant from valid0, valid1 and rr_ptr. Combinational, no state.
- rr_ptr lives in the scheduler.

Test Plan:
- Single job: req0 op=3, a=5, b=6; calculator model returns done with 11 at the 5th cycle after go.
  - Required: resp_valid at N+7 with resp_id=0, data=11, err=0; jobs_done=1.
- Contention: req0 and req1 both valid continuously after reset.
  - Required: grants go 0,1,0,1 and are never simultaneous.
  - Required: each requester sees exactly one ready pulse per job.
- Backpressure: hold resp_ready=0 for 10 cycles in RESP.
  - Required: outputs stable and resp_valid stays 1.
  - Required: no req_ready; accept resumes only after the handshake.
- Timeout: calculator model never asserts done, TIMEOUT=16.
  - Required: RESP is entered 16 cycles after entering WAIT, with err=1 and data=0.
  - Required: jobs_done unchanged.
- Async reset in WAIT: assert rst for a partial cycle.
  - Required: all outputs 0 immediately and state=IDLE.
  - Required: the next job is granted to req0 first.
- Counter wrap: 256 successful jobs.
  - Required: jobs_done goes 255 to 0 and busy drops between jobs.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator job scheduler and its bench:
// opcodes, scheduler state encoding, calculator control-unit states.
package calc_pkg;

  localparam logic [1:0] OP_XOR = 2'd0;
  localparam logic [1:0] OP_AND = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_ADD = 2'd3;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_ISSUE = 2'd1,
    SCH_WAIT  = 2'd2,
    SCH_RESP  = 2'd3
  } sched_state_e;

  // Calculator control-unit states, exported for monitors that watch the calculator.
  typedef enum logic [2:0] {
    CU_IDLE   = 3'd0,
    CU_WRITE1 = 3'd1,
    CU_WRITE2 = 3'd2,
    CU_EXEC   = 3'd3,
    CU_SETTLE = 3'd4,
    CU_OUTPUT = 3'd5
  } cu_state_e;

endpackage

// File: rtl/calc_rr_arb2.sv
// Two-way round-robin grant. rr_ptr holds the last winner; on contention
// the other requester wins. Purely combinational.
module calc_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic rr_ptr,
  output logic grant0,
  output logic grant1
);

  always_comb begin
    grant0 = valid0;
    grant1 = valid1;
    if (valid0 && valid1) begin
      grant0 = rr_ptr;
      grant1 = !rr_ptr;
    end
  end

endmodule

// File: rtl/calc_job_scheduler.sv
// Shares one calculator between two requesters: round-robin accept, one job
// in flight, go pulse, bounded wait for done, response with requester id.
//
// state | meaning
// IDLE  | no job; ready offered to the granted requester
// ISSUE | one-cycle go pulse to the calculator, timeout counter cleared
// WAIT  | waiting for calc_done or timeout
// RESP  | response held until resp_ready
module calc_job_scheduler
  import calc_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             calc_go,
  output logic [1:0]       calc_op,
  output logic [WIDTH-1:0] calc_a,
  output logic [WIDTH-1:0] calc_b,
  input  logic             calc_done,
  input  logic [WIDTH-1:0] calc_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             busy,
  output logic [7:0]       jobs_done
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  sched_state_e     state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [7:0]       jobs_q, jobs_d;
  logic             grant0, grant1;

  calc_rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .rr_ptr (rr_ptr_q),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // Ready is gated by rst so every output reads 0 while reset is held.
  assign req0_ready = !rst && (state_q == SCH_IDLE) && grant0;
  assign req1_ready = !rst && (state_q == SCH_IDLE) && grant1;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    err_d    = err_q;
    jobs_d   = jobs_q;
    case (state_q)
      SCH_IDLE: begin
        if (req0_valid && req0_ready) begin
          op_d     = req0_op;
          a_d      = req0_a;
          b_d      = req0_b;
          id_d     = 1'b0;
          rr_ptr_d = 1'b0;
          state_d  = SCH_ISSUE;
        end else if (req1_valid && req1_ready) begin
          op_d     = req1_op;
          a_d      = req1_a;
          b_d      = req1_b;
          id_d     = 1'b1;
          rr_ptr_d = 1'b1;
          state_d  = SCH_ISSUE;
        end
      end
      SCH_ISSUE: begin
        cnt_d   = '0;
        state_d = SCH_WAIT;
      end
      SCH_WAIT: begin
        // done is checked first so it wins on the timeout cycle
        if (calc_done) begin
          data_d  = calc_result;
          err_d   = 1'b0;
          state_d = SCH_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = SCH_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SCH_RESP: begin
        if (resp_ready) begin
          state_d = SCH_IDLE;
          if (!err_q) jobs_d = jobs_q + 8'd1;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCH_IDLE;
      rr_ptr_q <= 1'b1;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      jobs_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      err_q    <= err_d;
      jobs_q   <= jobs_d;
    end
  end

  assign calc_go    = (state_q == SCH_ISSUE);
  assign calc_op    = op_q;
  assign calc_a     = a_q;
  assign calc_b     = b_q;
  assign resp_valid = (state_q == SCH_RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign busy       = (state_q != SCH_IDLE);
  assign jobs_done  = jobs_q;

endmodule

// File: tb/tb_calc_job_scheduler.sv
// Scoreboard bench for calc_job_scheduler: random jobs, a behavioural calculator,
// and a reference model of arbitration, latency and response contents.
module tb_calc_job_scheduler;
  import calc_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    int         d;
    int         gap;
  } job_t;

  typedef struct {
    logic       id;
    logic [3:0] data;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       calc_go, calc_done;
  logic [1:0] calc_op;
  logic [3:0] calc_a, calc_b, calc_result;
  logic       resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [3:0] resp_data;
  logic [7:0] jobs_done;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  job_t q0[$];
  job_t q1[$];
  job_t pend0, pend1, cur;
  logic has0, has1;
  int   pd0, pd1, go_d = 0;
  exp_t sb_q[$];
  logic order_q[$];
  logic outstanding = 1'b0;
  logic rr_m = 1'b1;
  int   acc_cyc = 0;
  logic have_cur = 1'b0;
  logic [7:0] exp_jobs = 8'd0;
  int   resp_mode = 0;

  calc_job_scheduler #(.WIDTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .calc_go(calc_go), .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
    .calc_done(calc_done), .calc_result(calc_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy), .jobs_done(jobs_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_calc(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    case (op)
      OP_ADD:  r = int'(a) + int'(b);
      OP_SUB:  r = int'(a) - int'(b);
      OP_AND:  r = int'(a & b);
      default: r = int'(a ^ b);
    endcase
    return r[3:0];
  endfunction

  function automatic job_t mk_job(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                  input int d, input int gap);
    job_t j;
    j.op = op; j.a = a; j.b = b; j.d = d; j.gap = gap;
    return j;
  endfunction

  function automatic job_t rnd_job(input int d, input int gap);
    return mk_job(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), d, gap);
  endfunction

  function automatic logic [31:0] outs_vec();
    return 32'({req0_ready, req1_ready, calc_go, calc_op, calc_a, calc_b,
                resp_valid, resp_id, resp_data, resp_err, busy, jobs_done});
  endfunction

  // requester drivers: present queued jobs, drop/advance after each handshake
  initial begin : drv_req
    logic hs0, hs1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    has0 = 0; has1 = 0; pd0 = 0; pd1 = 0;
    forever begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (hs0) begin req0_valid = 0; has0 = 0; end
      if (hs1) begin req1_valid = 0; has1 = 0; end
      if (!has0 && q0.size() > 0) begin pend0 = q0.pop_front(); has0 = 1; end
      if (!has1 && q1.size() > 0) begin pend1 = q1.pop_front(); has1 = 1; end
      if (has0 && !req0_valid) begin
        if (pend0.gap > 0) pend0.gap--;
        else begin
          req0_valid = 1; req0_op = pend0.op; req0_a = pend0.a; req0_b = pend0.b; pd0 = pend0.d;
        end
      end
      if (has1 && !req1_valid) begin
        if (pend1.gap > 0) pend1.gap--;
        else begin
          req1_valid = 1; req1_op = pend1.op; req1_a = pend1.a; req1_b = pend1.b; pd1 = pend1.d;
        end
      end
    end
  end

  initial begin : drv_resp
    int bp;
    bp = 0; resp_ready = 0;
    forever begin
      @(posedge clk); #1;
      bp = resp_valid ? bp + 1 : 0;
      case (resp_mode)
        0:       resp_ready = 1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = (bp > 10);
      endcase
    end
  end

  // calculator: done (held two cycles) d cycles after the go cycle; d outside 1..17 never answers
  initial begin : calc_model
    int d;
    calc_done = 0; calc_result = 0;
    forever begin
      @(negedge clk);
      if (calc_go && !rst) begin
        d = go_d;
        if (d >= 1 && d <= TMO + 1) begin
          repeat (d) @(posedge clk);
          #1; calc_done = 1; calc_result = ref_calc(calc_op, calc_a, calc_b);
          @(posedge clk);
          @(posedge clk); #1; calc_done = 0; calc_result = 0;
        end
      end
    end
  end

  // request side: arbitration model, go timing, operand hold, scoreboard push
  initial begin : mon_req
    logic e0, e1, id;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0; rr_m = 1;
      end else begin
        e0 = 0; e1 = 0;
        if (!outstanding) begin
          if (req0_valid && req1_valid) begin e0 = rr_m; e1 = !rr_m; end
          else begin e0 = req0_valid; e1 = req1_valid; end
        end
        chk("req_ready", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
        chk("busy", 32'(busy), 32'(outstanding));
        chk("calc_go", 32'(calc_go), 32'(outstanding && cyc == acc_cyc + 1));
        if (outstanding && cyc > acc_cyc)
          chk("calc_operands", 32'({calc_op, calc_a, calc_b}), 32'({cur.op, cur.a, cur.b}));
        if (outstanding && resp_valid && resp_ready) outstanding = 0;
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          id = !(req0_valid && req0_ready);
          if (id) cur = mk_job(req1_op, req1_a, req1_b, pd1, 0);
          else    cur = mk_job(req0_op, req0_a, req0_b, pd0, 0);
          e.id   = id;
          e.err  = !(cur.d >= 1 && cur.d <= TMO);
          e.data = e.err ? 4'd0 : ref_calc(cur.op, cur.a, cur.b);
          e.acc  = cyc;
          e.lat  = e.err ? TMO + 2 : cur.d + 2;
          sb_q.push_back(e);
          order_q.push_back(id);
          outstanding = 1; acc_cyc = cyc; rr_m = id; go_d = cur.d;
        end
      end
    end
  end

  // response side: pops the scoreboard and checks timing, contents, hold, counter
  initial begin : mon_resp
    exp_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete(); have_cur = 0; exp_jobs = 0;
      end else begin
        if (!have_cur) begin
          if (sb_q.size() == 0) chk("resp_valid_idle", 32'(resp_valid), 32'd0);
          else begin
            chk("resp_latency", 32'(resp_valid), 32'(cyc == sb_q[0].acc + sb_q[0].lat));
            if (resp_valid) begin f = sb_q.pop_front(); have_cur = 1; end
          end
        end else chk("resp_hold", 32'(resp_valid), 32'd1);
        if (have_cur) begin
          chk("resp_id", 32'(resp_id), 32'(f.id));
          chk("resp_data", 32'(resp_data), 32'(f.data));
          chk("resp_err", 32'(resp_err), 32'(f.err));
          if (resp_ready) begin
            chk("jobs_done", 32'(jobs_done), 32'(exp_jobs));
            if (!f.err) exp_jobs++;
            have_cur = 0;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !has0 && !has1 && !req0_valid && !req1_valid &&
                 !outstanding && sb_q.size() == 0 && !have_cur) && n < budget);
    chk({"drain_", tag}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
  endtask

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached, fails so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int jd, n, r, d;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
    chk("reset_outputs", outs_vec(), 32'd0);

    // single nominal job
    q0.push_back(mk_job(OP_ADD, 4'd5, 4'd6, 5, 0));
    wait_idle(100, "single");
    chk("jobs_done_single", 32'(jobs_done), 32'd1);

    // contention straight out of reset
    do_reset();
    order_q.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(rnd_job($urandom_range(1, TMO), 0));
      q1.push_back(rnd_job($urandom_range(1, TMO), 0));
    end
    wait_idle(400, "contention");
    chk("grant_count", 32'(order_q.size()), 32'd8);
    foreach (order_q[i]) chk("grant_order", 32'(order_q[i]), 32'(i % 2));

    // backpressure with the other requester waiting
    resp_mode = 2;
    q0.push_back(rnd_job(3, 0));
    q1.push_back(rnd_job(2, 3));
    wait_idle(200, "backpressure");
    resp_mode = 0;

    // timeouts: never done, and done arriving only in RESP
    jd = int'(jobs_done);
    q0.push_back(rnd_job(99, 0));
    q1.push_back(rnd_job(TMO + 1, 0));
    wait_idle(200, "timeout");
    chk("jobs_done_timeout", 32'(jobs_done), 32'(jd));
    q0.push_back(rnd_job(TMO, 0));
    wait_idle(100, "done_on_last");
    chk("jobs_done_last", 32'(jobs_done), 32'(8'(jd + 1)));

    // random mix with random consumer readiness
    resp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 20);
      d = (r <= TMO) ? r : ((r <= 18) ? TMO + 1 : 99);
      if ($urandom_range(0, 1) == 0) q0.push_back(rnd_job(d, $urandom_range(0, 3)));
      else                           q1.push_back(rnd_job(d, $urandom_range(0, 3)));
    end
    wait_idle(4000, "random");
    resp_mode = 0;

    // asynchronous reset while waiting on the calculator
    q1.push_back(rnd_job(99, 0));
    n = 0;
    while (!(outstanding && cyc == acc_cyc + 4) && n < 60) begin @(negedge clk); #1; n++; end
    chk("reach_wait", 32'(n < 60), 32'd1);
    @(posedge clk); #3 rst = 1;
    #1 chk("async_reset_outputs", outs_vec(), 32'd0);
    #3 rst = 0;
    order_q.delete();
    q0.push_back(rnd_job(2, 0));
    q1.push_back(rnd_job(2, 0));
    wait_idle(100, "after_reset");
    chk("first_grant_after_reset", 32'(order_q[0]), 32'd0);

    // jobs_done wrap
    do_reset();
    for (int i = 0; i < 255; i++) begin
      if ($urandom_range(0, 1) == 0) q0.push_back(rnd_job($urandom_range(1, 4), 0));
      else                           q1.push_back(rnd_job($urandom_range(1, 4), 0));
    end
    wait_idle(4000, "wrap");
    chk("jobs_done_255", 32'(jobs_done), 32'd255);
    q1.push_back(rnd_job(1, 0));
    wait_idle(100, "wrap_last");
    chk("jobs_done_wrap", 32'(jobs_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
